// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_dec_if / alu_op_if
//  Description : Handshake bundles around the ALU issue stage.
//                alu_dec_if carries decoded-stage bundles into the stage
//                (instruction, PC, register read data). alu_op_if carries
//                ALU operands and control out of it, towards EX.
//  Revision    : 1.0 - initial release
// ============================================================================

// Upstream (decode) side: the decode stage is master, the issue stage slave.
interface alu_dec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_rs1_data;
  logic [DATA_WIDTH-1:0] in_rs2_data;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data,
    output in_ready
  );
endinterface

// Downstream (EX) side: the issue stage is master, the ALU/EX stage slave.
interface alu_op_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] input1;
  logic [DATA_WIDTH-1:0] input2;
  logic [3:0]            alu_control;
  logic                  out_is_branch;
  logic [2:0]            out_funct3;
  logic                  out_illegal;

  modport master (
    output out_valid, input1, input2, alu_control, out_is_branch,
           out_funct3, out_illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, input1, input2, alu_control, out_is_branch,
           out_funct3, out_illegal,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : RV32I ALU issue stage. Decodes an instruction bundle into
//                ALU operands and a 4-bit alu_control code, then registers it
//                at the ID/EX boundary behind a valid/ready handshake with a
//                2-entry skid buffer (main output register + skid register).
//                in_ready comes straight from a flop, so there is no
//                combinational path from out_ready back to upstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int         DATA_WIDTH   = 32,
  parameter logic [3:0] ILLEGAL_CTRL = 4'b0000
) (
  input  wire logic clk,
  input  wire logic reset_n,
  alu_dec_if.slave  dec,
  alu_op_if.master  op
);

  // ALU operation codes
  localparam logic [3:0] c_ALU_AND  = 4'b0001;
  localparam logic [3:0] c_ALU_OR   = 4'b0010;
  localparam logic [3:0] c_ALU_ADD  = 4'b0011;
  localparam logic [3:0] c_ALU_SUB  = 4'b0100;
  localparam logic [3:0] c_ALU_XOR  = 4'b0101;
  localparam logic [3:0] c_ALU_SLL  = 4'b0110;
  localparam logic [3:0] c_ALU_SRL  = 4'b0111;
  localparam logic [3:0] c_ALU_SRA  = 4'b1000;
  localparam logic [3:0] c_ALU_SLT  = 4'b1001;
  localparam logic [3:0] c_ALU_SLTU = 4'b1010;

  // RV32I major opcodes handled here
  localparam logic [6:0] c_OPC_R      = 7'b0110011;
  localparam logic [6:0] c_OPC_I      = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] c_F7_ZERO = 7'b0000000;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;

  // One registered ALU bundle (used for both main and skid entries)
  typedef struct packed {
    logic [DATA_WIDTH-1:0] in1;
    logic [DATA_WIDTH-1:0] in2;
    logic [3:0]            ctrl;
    logic                  is_branch;
    logic [2:0]            funct3;
    logic                  illegal;
  } bundle_t;

  // Instruction fields and immediates
  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [6:0]            w_funct7;
  logic [DATA_WIDTH-1:0] w_imm_i;
  logic [DATA_WIDTH-1:0] w_imm_s;
  logic [DATA_WIDTH-1:0] w_imm_u;
  logic [DATA_WIDTH-1:0] w_shamt;

  assign w_opcode = dec.in_instr[6:0];
  assign w_funct3 = dec.in_instr[14:12];
  assign w_funct7 = dec.in_instr[31:25];
  assign w_imm_i  = {{(DATA_WIDTH-12){dec.in_instr[31]}}, dec.in_instr[31:20]};
  assign w_imm_s  = {{(DATA_WIDTH-12){dec.in_instr[31]}}, dec.in_instr[31:25],
                     dec.in_instr[11:7]};
  assign w_imm_u  = {{(DATA_WIDTH-32){dec.in_instr[31]}}, dec.in_instr[31:12], 12'b0};
  assign w_shamt  = {{(DATA_WIDTH-5){1'b0}}, dec.in_instr[24:20]};

  // Raw decode before illegal masking
  logic [DATA_WIDTH-1:0] w_raw_in1;
  logic [DATA_WIDTH-1:0] w_raw_in2;
  logic [3:0]            w_raw_ctrl;
  logic                  w_raw_branch;
  logic                  w_raw_illegal;
  bundle_t               w_dec;

  // Combinational decode of operand selection and ALU operation
  always_comb begin
    w_raw_in1     = '0;
    w_raw_in2     = '0;
    w_raw_ctrl    = ILLEGAL_CTRL;
    w_raw_branch  = 1'b0;
    w_raw_illegal = 1'b0;
    case (w_opcode)
      c_OPC_R: begin
        w_raw_in1 = dec.in_rs1_data;
        w_raw_in2 = dec.in_rs2_data;
        case (w_funct3)
          3'b000: begin
            if (w_funct7 == c_F7_ZERO)     w_raw_ctrl = c_ALU_ADD;
            else if (w_funct7 == c_F7_ALT) w_raw_ctrl = c_ALU_SUB;
            else                           w_raw_illegal = 1'b1;
          end
          3'b101: begin
            if (w_funct7 == c_F7_ZERO)     w_raw_ctrl = c_ALU_SRL;
            else if (w_funct7 == c_F7_ALT) w_raw_ctrl = c_ALU_SRA;
            else                           w_raw_illegal = 1'b1;
          end
          default: begin
            if (w_funct7 != c_F7_ZERO) begin
              w_raw_illegal = 1'b1;
            end else begin
              case (w_funct3)
                3'b001:  w_raw_ctrl = c_ALU_SLL;
                3'b010:  w_raw_ctrl = c_ALU_SLT;
                3'b011:  w_raw_ctrl = c_ALU_SLTU;
                3'b100:  w_raw_ctrl = c_ALU_XOR;
                3'b110:  w_raw_ctrl = c_ALU_OR;
                default: w_raw_ctrl = c_ALU_AND;
              endcase
            end
          end
        endcase
      end
      c_OPC_I: begin
        w_raw_in1 = dec.in_rs1_data;
        w_raw_in2 = w_imm_i;
        case (w_funct3)
          3'b000: w_raw_ctrl = c_ALU_ADD;
          3'b010: w_raw_ctrl = c_ALU_SLT;
          3'b011: w_raw_ctrl = c_ALU_SLTU;
          3'b100: w_raw_ctrl = c_ALU_XOR;
          3'b110: w_raw_ctrl = c_ALU_OR;
          3'b111: w_raw_ctrl = c_ALU_AND;
          3'b001: begin
            w_raw_in2 = w_shamt;
            if (w_funct7 == c_F7_ZERO) w_raw_ctrl = c_ALU_SLL;
            else                       w_raw_illegal = 1'b1;
          end
          default: begin
            // funct3 101: instr[30] picks SRAI, all other funct7 bits must be 0
            w_raw_in2 = w_shamt;
            if (w_funct7 == c_F7_ZERO)     w_raw_ctrl = c_ALU_SRL;
            else if (w_funct7 == c_F7_ALT) w_raw_ctrl = c_ALU_SRA;
            else                           w_raw_illegal = 1'b1;
          end
        endcase
      end
      c_OPC_LUI: begin
        w_raw_in1  = '0;
        w_raw_in2  = w_imm_u;
        w_raw_ctrl = c_ALU_ADD;
      end
      c_OPC_AUIPC: begin
        w_raw_in1  = dec.in_pc;
        w_raw_in2  = w_imm_u;
        w_raw_ctrl = c_ALU_ADD;
      end
      c_OPC_LOAD: begin
        w_raw_in1  = dec.in_rs1_data;
        w_raw_in2  = w_imm_i;
        w_raw_ctrl = c_ALU_ADD;
      end
      c_OPC_STORE: begin
        w_raw_in1  = dec.in_rs1_data;
        w_raw_in2  = w_imm_s;
        w_raw_ctrl = c_ALU_ADD;
      end
      c_OPC_BRANCH: begin
        w_raw_in1    = dec.in_rs1_data;
        w_raw_in2    = dec.in_rs2_data;
        w_raw_branch = 1'b1;
        case (w_funct3)
          3'b000, 3'b001: w_raw_ctrl = c_ALU_SUB;
          3'b100, 3'b101: w_raw_ctrl = c_ALU_SLT;
          3'b110, 3'b111: w_raw_ctrl = c_ALU_SLTU;
          default:        w_raw_illegal = 1'b1;
        endcase
      end
      default: w_raw_illegal = 1'b1;
    endcase
  end

  // Illegal bundles carry no operands and no branch request, only funct3
  always_comb begin
    w_dec.funct3  = w_funct3;
    w_dec.illegal = w_raw_illegal;
    if (w_raw_illegal) begin
      w_dec.in1       = '0;
      w_dec.in2       = '0;
      w_dec.ctrl      = ILLEGAL_CTRL;
      w_dec.is_branch = 1'b0;
    end else begin
      w_dec.in1       = w_raw_in1;
      w_dec.in2       = w_raw_in2;
      w_dec.ctrl      = w_raw_ctrl;
      w_dec.is_branch = w_raw_branch;
    end
  end

  // Skid buffer state
  bundle_t r_main;
  bundle_t r_skid;
  logic    r_out_valid;
  logic    r_skid_valid;
  bundle_t w_reset_bundle;

  logic w_accept;
  logic w_drain;
  logic w_main_free;
  logic w_main_load;
  logic w_skid_load;

  assign w_reset_bundle = '{in1: '0, in2: '0, ctrl: ILLEGAL_CTRL, is_branch: 1'b0,
                            funct3: 3'b000, illegal: 1'b0};

  // in_ready is the inverted skid flag, so it depends only on a register
  assign dec.in_ready = ~r_skid_valid;
  assign w_accept     = dec.in_valid & ~r_skid_valid;
  assign w_drain      = r_out_valid & op.out_ready;
  // Main slot can take a new bundle this edge if it is empty or emptying
  assign w_main_free  = ~r_out_valid | w_drain;
  // Skid is older than any new input, so it refills main first
  assign w_main_load  = w_main_free & (r_skid_valid | w_accept);
  assign w_skid_load  = w_accept & ~w_main_free;

  // Main output register and skid register with FIFO ordering
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_main       <= w_reset_bundle;
      r_skid       <= w_reset_bundle;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_main_load) begin
        r_main      <= r_skid_valid ? r_skid : w_dec;
        r_out_valid <= 1'b1;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end

      if (w_skid_load) begin
        r_skid       <= w_dec;
        r_skid_valid <= 1'b1;
      end else if (w_main_free && r_skid_valid) begin
        r_skid_valid <= 1'b0;
      end
    end
  end

  assign op.out_valid     = r_out_valid;
  assign op.input1        = r_main.in1;
  assign op.input2        = r_main.in2;
  assign op.alu_control   = r_main.ctrl;
  assign op.out_is_branch = r_main.is_branch;
  assign op.out_funct3    = r_main.funct3;
  assign op.out_illegal   = r_main.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Directed vector bench for alu_issue_stage: a decode table
//                plus hand-written skid-buffer and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

  logic clk;
  logic reset_n;

  alu_dec_if #(.DATA_WIDTH(32)) u_dec_if ();
  alu_op_if  #(.DATA_WIDTH(32)) u_op_if ();

  alu_issue_stage #(
    .DATA_WIDTH   (32),
    .ILLEGAL_CTRL (4'b0000)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dec     (u_dec_if),
    .op      (u_op_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] e_in1;
    logic [31:0] e_in2;
    logic [3:0]  e_ctrl;
    logic        e_br;
    logic [2:0]  e_f3;
    logic        e_ill;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    u_dec_if.in_valid    = v;
    u_dec_if.in_instr    = instr;
    u_dec_if.in_pc       = pc;
    u_dec_if.in_rs1_data = rs1;
    u_dec_if.in_rs2_data = rs2;
  endtask

  task automatic check_bundle(input string tag, input vec_t v);
    check({tag, ".valid"},  {31'b0, u_op_if.out_valid},     32'd1);
    check({tag, ".in1"},    u_op_if.input1,                 v.e_in1);
    check({tag, ".in2"},    u_op_if.input2,                 v.e_in2);
    check({tag, ".ctrl"},   {28'b0, u_op_if.alu_control},   {28'b0, v.e_ctrl});
    check({tag, ".br"},     {31'b0, u_op_if.out_is_branch}, {31'b0, v.e_br});
    check({tag, ".f3"},     {29'b0, u_op_if.out_funct3},    {29'b0, v.e_f3});
    check({tag, ".ill"},    {31'b0, u_op_if.out_illegal},   {31'b0, v.e_ill});
  endtask

  // add x3,x1,x2 with a chosen rs1 tag, used by the sequences
  function automatic vec_t add_vec(input logic [31:0] tag);
    vec_t v;
    v = '{32'h002081B3, 32'h0, tag, 32'h5, tag, 32'h5, 4'b0011, 1'b0, 3'b000, 1'b0};
    return v;
  endfunction

  initial begin
    vec_t a, b, c;
    n_checks = 0;
    n_errors = 0;

    //            instr         pc          rs1          rs2          in1          in2          ctrl    br    f3      ill
    vecs[0]  = '{32'h002081B3, 32'h0,     32'h1234,     32'h5678,     32'h1234,     32'h5678,     4'b0011, 1'b0, 3'b000, 1'b0}; // add
    vecs[1]  = '{32'h402081B3, 32'h0,     32'h1234,     32'h5678,     32'h1234,     32'h5678,     4'b0100, 1'b0, 3'b000, 1'b0}; // sub
    vecs[2]  = '{32'hFFF00293, 32'h0,     32'h0,        32'h9,        32'h0,        32'hFFFFFFFF, 4'b0011, 1'b0, 3'b000, 1'b0}; // addi -1
    vecs[3]  = '{32'h4030D093, 32'h0,     32'h80000000, 32'h9,        32'h80000000, 32'h3,        4'b1000, 1'b0, 3'b101, 1'b0}; // srai
    vecs[4]  = '{32'h123450B7, 32'h0,     32'hDEAD,     32'h9,        32'h0,        32'h12345000, 4'b0011, 1'b0, 3'b101, 1'b0}; // lui
    vecs[5]  = '{32'h00001097, 32'h100,   32'hDEAD,     32'h9,        32'h100,      32'h1000,     4'b0011, 1'b0, 3'b001, 1'b0}; // auipc
    vecs[6]  = '{32'h0020C463, 32'h0,     32'h5,        32'h7,        32'h5,        32'h7,        4'b1001, 1'b1, 3'b100, 1'b0}; // blt
    vecs[7]  = '{32'hFFFFFFFF, 32'h40,    32'hAAAA,     32'hBBBB,     32'h0,        32'h0,        4'b0000, 1'b0, 3'b111, 1'b1}; // bad opcode
    vecs[8]  = '{32'h022081B3, 32'h0,     32'hAAAA,     32'hBBBB,     32'h0,        32'h0,        4'b0000, 1'b0, 3'b000, 1'b1}; // mul
    vecs[9]  = '{32'h0020C1B3, 32'h0,     32'h11,       32'h22,       32'h11,       32'h22,       4'b0101, 1'b0, 3'b100, 1'b0}; // xor
    vecs[10] = '{32'h0020B1B3, 32'h0,     32'h11,       32'h22,       32'h11,       32'h22,       4'b1010, 1'b0, 3'b011, 1'b0}; // sltu
    vecs[11] = '{32'h4020D1B3, 32'h0,     32'h11,       32'h22,       32'h11,       32'h22,       4'b1000, 1'b0, 3'b101, 1'b0}; // sra
    vecs[12] = '{32'h00309093, 32'h0,     32'h77,       32'h22,       32'h77,       32'h3,        4'b0110, 1'b0, 3'b001, 1'b0}; // slli
    vecs[13] = '{32'hFE20AE23, 32'h0,     32'h1000,     32'h22,       32'h1000,     32'hFFFFFFFC, 4'b0011, 1'b0, 3'b010, 1'b0}; // sw -4
    vecs[14] = '{32'hFF80A183, 32'h0,     32'h2000,     32'h22,       32'h2000,     32'hFFFFFFF8, 4'b0011, 1'b0, 3'b010, 1'b0}; // lw -8
    vecs[15] = '{32'h0020E463, 32'h0,     32'h3,        32'h4,        32'h3,        32'h4,        4'b1010, 1'b1, 3'b110, 1'b0}; // bltu

    // Reset with junk on the input that must be ignored
    reset_n = 1'b0;
    u_op_if.out_ready = 1'b1;
    drive(1'b1, 32'h002081B3, 32'h0, 32'h1, 32'h2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.valid",    {31'b0, u_op_if.out_valid},   32'd0);
    check("rst.in_ready", {31'b0, u_dec_if.in_ready},   32'd1);
    check("rst.in1",      u_op_if.input1,               32'd0);
    check("rst.in2",      u_op_if.input2,               32'd0);
    check("rst.ctrl",     {28'b0, u_op_if.alu_control}, 32'd0);
    check("rst.f3",       {29'b0, u_op_if.out_funct3},  32'd0);
    check("rst.br",       {31'b0, u_op_if.out_is_branch}, 32'd0);
    check("rst.ill",      {31'b0, u_op_if.out_illegal}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Decode table, one bundle at a time with out_ready held high
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      check_bundle($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d.drop", i), {31'b0, u_op_if.out_valid}, 32'd0);
    end

    // Back-to-back throughput: two bundles on consecutive edges, ready high
    a = add_vec(32'hA1);
    b = add_vec(32'hB2);
    drive(1'b1, a.instr, a.pc, a.rs1, a.rs2);
    @(posedge clk);
    @(negedge clk);
    check_bundle("tp.a", a);
    drive(1'b1, b.instr, b.pc, b.rs1, b.rs2);
    @(posedge clk);
    @(negedge clk);
    check_bundle("tp.b", b);
    check("tp.in_ready", {31'b0, u_dec_if.in_ready}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);

    // Stall with A, B, C offered back to back
    a = add_vec(32'h11);
    b = add_vec(32'h22);
    c = add_vec(32'h33);
    u_op_if.out_ready = 1'b0;
    drive(1'b1, a.instr, a.pc, a.rs1, a.rs2);
    @(posedge clk);
    @(negedge clk);
    check("stall.rdy_a", {31'b0, u_dec_if.in_ready}, 32'd1);
    drive(1'b1, b.instr, b.pc, b.rs1, b.rs2);
    @(posedge clk);
    @(negedge clk);
    check_bundle("stall.a1", a);
    check("stall.rdy_b", {31'b0, u_dec_if.in_ready}, 32'd0);
    drive(1'b1, c.instr, c.pc, c.rs1, c.rs2);
    @(posedge clk);
    @(negedge clk);
    check_bundle("stall.a2", a);
    check("stall.rdy_c", {31'b0, u_dec_if.in_ready}, 32'd0);
    u_op_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_bundle("drain.b", b);
    check("drain.rdy", {31'b0, u_dec_if.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    check_bundle("drain.c", c);
    @(posedge clk);
    @(negedge clk);
    check("drain.empty", {31'b0, u_op_if.out_valid}, 32'd0);

    // Fill both entries, then reset for one edge
    u_op_if.out_ready = 1'b0;
    drive(1'b1, a.instr, a.pc, a.rs1, a.rs2);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, b.instr, b.pc, b.rs1, b.rs2);
    @(posedge clk);
    @(negedge clk);
    check("full.rdy", {31'b0, u_dec_if.in_ready}, 32'd0);
    reset_n = 1'b0;
    drive(1'b1, c.instr, c.pc, c.rs1, c.rs2);
    @(posedge clk);
    @(negedge clk);
    check("mrst.valid",    {31'b0, u_op_if.out_valid}, 32'd0);
    check("mrst.in_ready", {31'b0, u_dec_if.in_ready}, 32'd1);
    check("mrst.in1",      u_op_if.input1,             32'd0);
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    u_op_if.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("mrst.quiet%0d", k), {31'b0, u_op_if.out_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
